median_window_seq: RTL and testbench

Sequencer for the median-filter window buffer. It streams one (2·FILTER+1)² pixel window into the buffer's write port, then reads the whole window back out in address order to the downstream median sorter. The read-back uses a valid/ready handshake with backpressure. It sits between the pixel window extractor (upstream) and the sorting network (downstream), and is the only master of the buffer's write and read ports.

---
 rtl/median_window_seq_if.sv | 20 ++
 rtl/median_window_seq.sv | 91 +++++++++
 tb/tb_median_window_seq.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_seq_if.sv
// median_window_seq_if: pixel stream bundle, upstream into the sequencer and downstream to the median sorter
interface median_window_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_s_valid;
    logic             o_s_ready;
    logic [WIDTH-1:0] i_s_data;
    logic             o_m_valid;
    logic             i_m_ready;
    logic [WIDTH-1:0] o_m_data;
    logic             o_m_last;
    modport master (
        input  i_s_valid, i_s_data, i_m_ready,
        output o_s_ready, o_m_valid, o_m_data, o_m_last
    );
    modport slave (
        output i_s_valid, i_s_data, i_m_ready,
        input  o_s_ready, o_m_valid, o_m_data, o_m_last
    );
endinterface

// File: rtl/median_window_seq.sv
// median_window_seq: fills a median-filter window buffer, then streams it back in address order to the sorter
module median_window_seq #(
    parameter int WIDTH  = 8,
    parameter int FILTER = 3,
    localparam int N     = (2*FILTER+1)*(2*FILTER+1),
    localparam int AW    = $clog2(N)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    median_window_seq_if.master      io_bus,
    output logic                     o_wren,
    output logic [AW-1:0]            o_waddr,
    output logic [WIDTH-1:0]         o_wdata,
    output logic [AW-1:0]            o_raddr,
    input  logic [WIDTH-1:0]         i_rdata,
    output logic                     o_busy,
    output logic                     o_done
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    localparam logic [AW-1:0] W_LAST = AW'(N-1);
    localparam logic [AW:0]   R_N    = (AW+1)'(N);
    localparam logic [AW:0]   R_LAST = (AW+1)'(N-1);
    state_t           r_state, w_state_nx;
    logic [AW-1:0]    r_wcnt, r_raddr;
    logic [AW:0]      r_rcnt;
    logic             r_inflight, r_inflight_last, r_done;
    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_d0, r_d1;
    logic             r_l0, r_l1;
    logic             w_accept, w_pop, w_issue, w_last_pop, w_push_lo;
    logic [2:0]       w_level;

    assign w_accept   = r_state == FILL && io_bus.i_s_valid;
    assign w_pop      = r_occ != 2'd0 && io_bus.i_m_ready;
    assign w_last_pop = w_pop && r_l0;
    // occupancy the FIFO would reach if a read issued now also landed: keeps it at most two deep
    assign w_level    = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue    = r_state == DRAIN && r_rcnt < R_N && w_level < 3'd2;
    assign w_push_lo  = r_inflight && (r_occ - 2'(w_pop)) == 2'd0;

    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && i_start) w_state_nx = FILL;
        if (w_accept && r_wcnt == W_LAST) w_state_nx = DRAIN;
        if (r_state == DRAIN && w_last_pop) w_state_nx = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_state_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wcnt          <= '0;
            r_rcnt          <= '0;
            r_raddr         <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_occ           <= 2'd0;
            r_d0            <= '0;
            r_d1            <= '0;
            r_l0            <= 1'b0;
            r_l1            <= 1'b0;
        end else begin
            r_done          <= w_last_pop;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && r_rcnt == R_LAST;
            r_raddr         <= o_raddr;
            r_wcnt          <= r_state != FILL ? '0 : !w_accept ? r_wcnt : r_wcnt == W_LAST ? '0 : r_wcnt + 1'b1;
            r_rcnt          <= r_state != DRAIN || w_last_pop ? '0 : r_rcnt + (AW+1)'(w_issue);
            r_occ           <= r_state != DRAIN || w_last_pop ? 2'd0 : r_occ + 2'(r_inflight) - 2'(w_pop);
            if (w_push_lo) {r_d0, r_l0} <= {i_rdata, r_inflight_last};
            else if (w_pop) {r_d0, r_l0} <= {r_d1, r_l1};
            if (r_inflight && !w_push_lo) {r_d1, r_l1} <= {i_rdata, r_inflight_last};
        end
    end

    assign io_bus.o_s_ready = r_state == FILL;
    assign io_bus.o_m_valid = r_occ != 2'd0;
    assign io_bus.o_m_data  = r_d0;
    assign io_bus.o_m_last  = r_occ != 2'd0 && r_l0;
    assign o_wren           = w_accept;
    assign o_waddr          = r_wcnt;
    assign o_wdata          = r_state == FILL ? io_bus.i_s_data : '0;
    assign o_raddr          = w_issue ? r_rcnt[AW-1:0] : r_raddr;
    assign o_busy           = r_state != IDLE;
    assign o_done           = r_done;
endmodule

// File: tb/tb_median_window_seq.sv
// tb_median_window_seq: directed checks of the window sequencer with a registered-read buffer model
module tb_median_window_seq;
    localparam int W = 8;
    localparam int NA = 49, AWA = 6, NB = 9, AWB = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int errors = 0, checks = 0;

    median_window_seq_if #(.WIDTH(W)) bus_a ();
    median_window_seq_if #(.WIDTH(W)) bus_b ();
    logic start_a = 1'b0, wren_a, busy_a, done_a;
    logic start_b = 1'b0, wren_b, busy_b, done_b;
    logic [AWA-1:0] waddr_a, raddr_a;
    logic [AWB-1:0] waddr_b, raddr_b;
    logic [W-1:0] wdata_a, rdata_a, wdata_b, rdata_b;
    logic [W-1:0] mem_a [64];
    logic [W-1:0] mem_b [16];

    median_window_seq #(.WIDTH(W), .FILTER(3)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .io_bus(bus_a),
        .o_wren(wren_a), .o_waddr(waddr_a), .o_wdata(wdata_a), .o_raddr(raddr_a),
        .i_rdata(rdata_a), .o_busy(busy_a), .o_done(done_a)
    );
    median_window_seq #(.WIDTH(W), .FILTER(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .io_bus(bus_b),
        .o_wren(wren_b), .o_waddr(waddr_b), .o_wdata(wdata_b), .o_raddr(raddr_b),
        .i_rdata(rdata_b), .o_busy(busy_b), .o_done(done_b)
    );

    always @(posedge clk) begin
        if (wren_a) mem_a[waddr_a] <= wdata_a;
        rdata_a <= mem_a[raddr_a];
        if (wren_b) mem_b[waddr_b] <= wdata_b;
        rdata_b <= mem_b[raddr_b];
    end

    // monitor on the DUT-A ports: write log, output log, stall stability, writes under reset
    logic [AWA-1:0] wa_q[$];
    logic [W-1:0] wd_q[$], od_q[$];
    logic ol_q[$];
    int stab_err = 0, rst_wr = 0, wlast_cyc = 0;
    logic prev_stall = 1'b0, prev_l = 1'b0;
    logic [W-1:0] prev_d = '0;
    always @(negedge clk) begin
        if (wren_a) begin
            wa_q.push_back(waddr_a);
            wd_q.push_back(wdata_a);
            wlast_cyc <= cyc;
        end
        if (wren_a && rst) rst_wr <= rst_wr + 1;
        if (bus_a.o_m_valid && bus_a.i_m_ready) begin
            od_q.push_back(bus_a.o_m_data);
            ol_q.push_back(bus_a.o_m_last);
        end
        if (prev_stall && !rst && !(bus_a.o_m_valid && bus_a.o_m_data == prev_d && bus_a.o_m_last == prev_l))
            stab_err <= stab_err + 1;
        prev_stall <= bus_a.o_m_valid && !bus_a.i_m_ready;
        prev_d <= bus_a.o_m_data;
        prev_l <= bus_a.o_m_last;
    end

    task automatic run_a(input int base, input bit gap, input bit rnd, input bit noise,
                         input int stop_w, input int stop_o, output int t0, output int tv, output int td);
        int p = 0, outs = 0;
        tv = -1;
        td = -1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 2000; k++) begin
            bus_a.i_s_valid = p < NA && (!gap || k % 2 == 0);
            bus_a.i_s_data = W'(base + p);
            bus_a.i_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_a = noise && k % 5 == 2;
            @(negedge clk);
            if (bus_a.i_s_valid && bus_a.o_s_ready) p++;
            if (bus_a.o_m_valid && bus_a.i_m_ready) outs++;
            if (tv < 0 && bus_a.o_m_valid) tv = cyc;
            if (done_a) begin
                td = cyc;
                break;
            end
            @(posedge clk); #1;
            if (p >= stop_w || outs >= stop_o) break;
        end
        bus_a.i_s_valid = 1'b0;
        bus_a.i_m_ready = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.i_s_valid = 1'b1;
        bus_a.i_s_data = 8'hAA;
        bus_a.i_m_ready = 1'b1;
        start_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wren_a, bus_a.o_s_ready, bus_a.o_m_valid, bus_a.o_m_last, busy_a, done_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {wren_a, bus_a.o_s_ready, bus_a.o_m_valid, bus_a.o_m_last, busy_a, done_a});
        end
        checks++;
        if (waddr_a !== '0 || raddr_a !== '0) begin
            errors++;
            $display("FAIL reset_addr: waddr=%0d raddr=%0d expected 0", waddr_a, raddr_a);
        end
        checks++;
        if (wdata_a !== '0 || bus_a.o_m_data !== '0) begin
            errors++;
            $display("FAIL reset_data: wdata=%0h m_data=%0h expected 0", wdata_a, bus_a.o_m_data);
        end
        start_a = 1'b0;
        bus_a.i_s_valid = 1'b0;
        bus_a.i_m_ready = 1'b0;
        bus_b.i_s_valid = 1'b0;
        bus_b.i_s_data = '0;
        bus_b.i_m_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_basic();
        int t0, tv, td, qw, qo, nw, no, bad;
        qw = wa_q.size();
        qo = od_q.size();
        run_a(0, 1'b0, 1'b0, 1'b0, 1000, 1000, t0, tv, td);
        checks++;
        if (td - t0 != 2*NA + 2) begin
            errors++;
            $display("FAIL basic_done_time: got %0d expected %0d", td - t0, 2*NA + 2);
        end
        checks++;
        if (tv - t0 != NA + 2) begin
            errors++;
            $display("FAIL basic_first_valid: got %0d expected %0d", tv - t0, NA + 2);
        end
        checks++;
        if (busy_a !== 1'b0 || bus_a.o_m_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_at_done: busy=%b m_valid=%b expected 0 0", busy_a, bus_a.o_m_valid);
        end
        nw = wa_q.size() - qw;
        bad = 0;
        for (int i = 0; i < nw; i++) if (wa_q[qw+i] !== AWA'(i) || wd_q[qw+i] !== W'(i)) bad++;
        checks++;
        if (nw != NA || bad != 0) begin
            errors++;
            $display("FAIL basic_writes: count=%0d bad=%0d expected count=%0d bad=0", nw, bad, NA);
        end
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (no != NA || bad != 0) begin
            errors++;
            $display("FAIL basic_outputs: count=%0d bad=%0d expected count=%0d bad=0", no, bad, NA);
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b expected 0", done_a);
        end
    endtask

    task automatic test_gaps();
        int t0, tv, td, qw, qo, nw, no, bad;
        qw = wa_q.size();
        qo = od_q.size();
        run_a(30, 1'b1, 1'b0, 1'b0, 1000, 1000, t0, tv, td);
        nw = wa_q.size() - qw;
        bad = 0;
        for (int i = 0; i < nw; i++) if (wa_q[qw+i] !== AWA'(i) || wd_q[qw+i] !== W'(30 + i)) bad++;
        checks++;
        if (nw != NA || bad != 0) begin
            errors++;
            $display("FAIL gaps_writes: count=%0d bad=%0d expected count=%0d bad=0", nw, bad, NA);
        end
        checks++;
        if (wlast_cyc - t0 != 2*(NA-1)) begin
            errors++;
            $display("FAIL gaps_fill_span: got %0d expected %0d", wlast_cyc - t0, 2*(NA-1));
        end
        checks++;
        if (tv - wlast_cyc != 3) begin
            errors++;
            $display("FAIL gaps_drain_entry: got %0d expected 3", tv - wlast_cyc);
        end
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(30 + i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (no != NA || bad != 0 || td < 0) begin
            errors++;
            $display("FAIL gaps_outputs: count=%0d bad=%0d done=%0d expected count=%0d bad=0", no, bad, td, NA);
        end
    endtask

    task automatic test_backpressure();
        int t0, tv, td, qo, no, bad, s0;
        qo = od_q.size();
        s0 = stab_err;
        run_a(50, 1'b0, 1'b1, 1'b0, 1000, 1000, t0, tv, td);
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(50 + i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (no != NA || bad != 0 || td < 0) begin
            errors++;
            $display("FAIL bp_outputs: count=%0d bad=%0d done=%0d expected count=%0d bad=0", no, bad, td, NA);
        end
        checks++;
        if (stab_err != s0) begin
            errors++;
            $display("FAIL bp_stall_stability: violations=%0d expected 0", stab_err - s0);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle_at_done: busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_start_ignored();
        int t0, tv, td, qw, qo, nw, no, bad;
        qw = wa_q.size();
        qo = od_q.size();
        run_a(100, 1'b0, 1'b0, 1'b1, 1000, 1000, t0, tv, td);
        checks++;
        if (td - t0 != 2*NA + 2) begin
            errors++;
            $display("FAIL start_ignored_time: got %0d expected %0d", td - t0, 2*NA + 2);
        end
        nw = wa_q.size() - qw;
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < nw; i++) if (wa_q[qw+i] !== AWA'(i)) bad++;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(100 + i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (nw != NA || no != NA || bad != 0) begin
            errors++;
            $display("FAIL second_window: writes=%0d outs=%0d bad=%0d expected %0d %0d 0", nw, no, bad, NA, NA);
        end
    endtask

    task automatic test_reset_mid();
        int t0, tv, td, qw, qo, nw, no, bad;
        qw = wa_q.size();
        run_a(0, 1'b0, 1'b0, 1'b0, 20, 1000, t0, tv, td);
        bus_a.i_s_valid = 1'b1;
        bus_a.i_s_data = 8'h55;
        rst = 1'b1;
        #1;
        checks++;
        if ({wren_a, bus_a.o_s_ready, busy_a, waddr_a, wdata_a} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: wren=%b s_ready=%b busy=%b waddr=%0d wdata=%0h expected all 0",
                     wren_a, bus_a.o_s_ready, busy_a, waddr_a, wdata_a);
        end
        nw = wa_q.size() - qw;
        checks++;
        if (nw != 20) begin
            errors++;
            $display("FAIL reset_mid_fill_writes: got %0d expected 20", nw);
        end
        @(posedge clk);
        @(negedge clk);
        bus_a.i_s_valid = 1'b0;
        rst = 1'b0;
        qo = od_q.size();
        run_a(0, 1'b0, 1'b0, 1'b0, 1000, 1000, t0, tv, td);
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (no != NA || bad != 0 || td - t0 != 2*NA + 2) begin
            errors++;
            $display("FAIL recover_after_fill_reset: outs=%0d bad=%0d time=%0d expected %0d 0 %0d", no, bad, td - t0, NA, 2*NA + 2);
        end
        qo = od_q.size();
        run_a(60, 1'b0, 1'b0, 1'b0, 1000, 10, t0, tv, td);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.o_m_valid, bus_a.o_m_last, busy_a, done_a, raddr_a, bus_a.o_m_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain: m_valid=%b m_last=%b busy=%b done=%b raddr=%0d m_data=%0h expected all 0",
                     bus_a.o_m_valid, bus_a.o_m_last, busy_a, done_a, raddr_a, bus_a.o_m_data);
        end
        checks++;
        if (od_q.size() - qo != 10) begin
            errors++;
            $display("FAIL reset_mid_drain_count: got %0d expected 10", od_q.size() - qo);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        qo = od_q.size();
        run_a(0, 1'b0, 1'b0, 1'b0, 1000, 1000, t0, tv, td);
        no = od_q.size() - qo;
        bad = 0;
        for (int i = 0; i < no; i++) if (od_q[qo+i] !== W'(i) || ol_q[qo+i] !== (i == NA-1)) bad++;
        checks++;
        if (no != NA || bad != 0 || td - t0 != 2*NA + 2) begin
            errors++;
            $display("FAIL recover_after_drain_reset: outs=%0d bad=%0d time=%0d expected %0d 0 %0d", no, bad, td - t0, NA, 2*NA + 2);
        end
        checks++;
        if (rst_wr != 0) begin
            errors++;
            $display("FAIL write_under_reset: got %0d writes expected 0", rst_wr);
        end
    endtask

    task automatic test_filter1();
        int t0, td = -1, p = 0, outs = 0, bad = 0;
        logic [AWB:0] rc_last = '0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 200; k++) begin
            bus_b.i_s_valid = p < NB;
            bus_b.i_s_data = W'(NB - p);
            bus_b.i_m_ready = 1'b1;
            @(negedge clk);
            if (bus_b.i_s_valid && bus_b.o_s_ready) p++;
            if (bus_b.o_m_valid && bus_b.i_m_ready) begin
                if (bus_b.o_m_data !== W'(NB - outs) || bus_b.o_m_last !== (outs == NB-1)) bad++;
                if (bus_b.o_m_last) rc_last = u_b.r_rcnt;
                outs++;
            end
            if (done_b) begin
                td = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        bus_b.i_s_valid = 1'b0;
        bus_b.i_m_ready = 1'b0;
        checks++;
        if (outs != NB || bad != 0) begin
            errors++;
            $display("FAIL f1_outputs: count=%0d bad=%0d expected count=%0d bad=0", outs, bad, NB);
        end
        checks++;
        if (td - t0 != 2*NB + 2) begin
            errors++;
            $display("FAIL f1_done_time: got %0d expected %0d", td - t0, 2*NB + 2);
        end
        checks++;
        if (rc_last !== (AWB+1)'(NB)) begin
            errors++;
            $display("FAIL f1_rcnt_at_last: got %0d expected %0d", rc_last, NB);
        end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL f1_idle_at_done: busy=%b expected 0", busy_b);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.i_s_valid = 1'b0;
        bus_a.i_s_data = '0;
        bus_a.i_m_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_filter1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
